// File: rtl/sleep_unit_mc.sv
// sleep_unit_mc: per-core RUN/SHUTDOWN/SLEEP control over APB (HCLK/HRESET, APB slave PADDR..PSLVERR, signal_i/core_busy_i in, fetch_en_o/clk_gate_core_o out)
module sleep_unit_mc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_CORES = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NB_CORES-1:0]       signal_i,
  input  logic [NB_CORES-1:0]       core_busy_i,
  output logic [NB_CORES-1:0]       fetch_en_o,
  output logic [NB_CORES-1:0]       clk_gate_core_o
);
  typedef enum logic [1:0] {RUN, SHUTDOWN, SLEEP} state_e;
  localparam logic [3:0] NBC = 4'(NB_CORES);
  state_e               state_q [NB_CORES];
  state_e               state_d [NB_CORES];
  logic [15:0]          tcnt_q  [NB_CORES];
  logic [15:0]          tcnt_d  [NB_CORES];
  logic [CNT_WIDTH-1:0] cnt_q   [NB_CORES];
  logic [CNT_WIDTH-1:0] cnt_d   [NB_CORES];
  logic [NB_CORES-1:0]  ctrl_q, ctrl_d, status_q, status_d, mask_q, mask_d, err_q, err_d, wake, abort;
  logic [15:0]          timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_rd;
  logic [31:0]          rdata;
  logic [4:0]           idx;
  logic                 acc, wr, cnt_sel, mapped, unused;
  assign acc     = PSEL & PENABLE;
  assign idx     = PADDR[6:2];
  assign cnt_sel = idx[4:3] == 2'b01 && {1'b0, idx[2:0]} < NBC;
  assign mapped  = idx < 5'd5 || cnt_sel;
  assign wr      = acc & PWRITE & mapped;
  assign wake    = signal_i & mask_q;
  assign unused  = ^{PADDR, PWDATA[31:16]};
  assign PREADY  = 1'b1;
  assign PRDATA  = acc && !PWRITE && !HRESET ? rdata : '0;
  assign PSLVERR = acc && !mapped && !HRESET;
  always_comb begin
    ctrl_d          = ctrl_q;
    mask_d          = mask_q;
    timeout_d       = timeout_q;
    status_d        = '0;
    abort           = '0;
    cnt_rd          = '0;
    fetch_en_o      = '1;
    clk_gate_core_o = '1;
    for (int c = 0; c < NB_CORES; c++) begin
      state_d[c] = state_q[c];
      tcnt_d[c]  = state_q[c] == SHUTDOWN ? tcnt_q[c] + 16'd1 : '0;
      if (state_q[c] == RUN) begin
        if (ctrl_q[c] && !wake[c]) state_d[c] = SHUTDOWN;
      end else if (state_q[c] == SHUTDOWN) begin
        abort[c]   = !wake[c] && core_busy_i[c] && timeout_q != '0 && tcnt_q[c] == timeout_q - 16'd1;
        state_d[c] = wake[c] || abort[c] ? RUN : !core_busy_i[c] ? SLEEP : SHUTDOWN;
      end else if (wake[c]) begin
        state_d[c] = RUN;
      end
      status_d[c] = state_q[c] == SLEEP;
      if (state_q[c] == SLEEP || wake[c] || abort[c]) ctrl_d[c] = 1'b0;
      cnt_d[c] = wr && cnt_sel && idx[2:0] == 3'(c) ? '0 :
                 state_q[c] == SLEEP && !(&cnt_q[c]) ? cnt_q[c] + 1'b1 : cnt_q[c];
      if (cnt_sel && idx[2:0] == 3'(c)) cnt_rd = cnt_q[c];
      fetch_en_o[c]      = !(state_q[c] == SHUTDOWN || (state_q[c] == RUN && ctrl_q[c] && !wake[c]));
      clk_gate_core_o[c] = state_q[c] != SLEEP || wake[c];
    end
    if (wr && idx == 5'd0) ctrl_d = PWDATA[NB_CORES-1:0];
    if (wr && idx == 5'd2) mask_d = PWDATA[NB_CORES-1:0];
    if (wr && idx == 5'd3) timeout_d = PWDATA[15:0];
    err_d = (err_q & ~(wr && idx == 5'd4 ? PWDATA[NB_CORES-1:0] : '0)) | abort;
    rdata = idx == 5'd0 ? 32'(ctrl_q) :
            idx == 5'd1 ? 32'(status_q) :
            idx == 5'd2 ? 32'(mask_q) :
            idx == 5'd3 ? 32'(timeout_q) :
            idx == 5'd4 ? 32'(err_q) :
            cnt_sel     ? 32'(cnt_rd) : '0;
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_q    <= '0;
      status_q  <= '0;
      mask_q    <= '1;
      err_q     <= '0;
      timeout_q <= '0;
      for (int c = 0; c < NB_CORES; c++) begin
        state_q[c] <= RUN;
        tcnt_q[c]  <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      for (int c = 0; c < NB_CORES; c++) begin
        state_q[c] <= state_d[c];
        tcnt_q[c]  <= tcnt_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end
endmodule

// File: tb/tb_sleep_unit_mc.sv
// tb_sleep_unit_mc: randomized and directed checks of sleep_unit_mc against a cycle-level behavioural model
module tb_sleep_unit_mc;
  logic        HCLK = 1'b0;
  logic        HRESET, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  signal_i, core_busy_i, fetch_en_o, clk_gate_core_o;
  int          total, bad;
  int          m_mode [4];
  int          m_wait [4];
  int          m_slept [4];
  int          m_req, m_mask, m_tmo, m_err, m_stat;
  sleep_unit_mc #(.APB_ADDR_WIDTH(12), .NB_CORES(4), .CNT_WIDTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .signal_i(signal_i), .core_busy_i(core_busy_i), .fetch_en_o(fetch_en_o),
    .clk_gate_core_o(clk_gate_core_o)
  );
  always #5 HCLK = ~HCLK;
  // model: mode 0 = running, 1 = waiting for idle, 2 = asleep
  function automatic void m_reset();
    for (int c = 0; c < 4; c++) begin
      m_mode[c]  = 0;
      m_wait[c]  = 0;
      m_slept[c] = 0;
    end
    m_req = 0; m_mask = 'hF; m_tmo = 0; m_err = 0; m_stat = 0;
  endfunction
  function automatic int m_wake(int c);
    int s;
    s = int'(signal_i);
    return (s >> c) & (m_mask >> c) & 1;
  endfunction
  function automatic logic [3:0] exp_fetch();
    logic [3:0] r;
    for (int c = 0; c < 4; c++)
      r[c] = !(m_mode[c] == 1 || (m_mode[c] == 0 && ((m_req >> c) & 1) == 1 && m_wake(c) == 0));
    return r;
  endfunction
  function automatic logic [3:0] exp_gate();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = m_mode[c] == 2 ? m_wake(c) == 1 : 1'b1;
    return r;
  endfunction
  function automatic logic [31:0] exp_read(int i);
    if (i == 0) return 32'(m_req);
    if (i == 1) return 32'(m_stat);
    if (i == 2) return 32'(m_mask);
    if (i == 3) return 32'(m_tmo);
    if (i == 4) return 32'(m_err);
    if (i >= 8 && i < 12) return 32'(m_slept[i-8]);
    return 32'd0;
  endfunction
  function automatic logic [31:0] exp_rdata();
    return PSEL && PENABLE && !PWRITE && !HRESET ? exp_read(int'(PADDR[6:2])) : 32'd0;
  endfunction
  function automatic logic exp_slverr();
    int i;
    i = int'(PADDR[6:2]);
    return PSEL && PENABLE && !HRESET && !(i < 5 || (i >= 8 && i < 12));
  endfunction
  function automatic void model_step();
    int busy, nreq, nstat, set, clr, i, wd, w, old;
    busy = int'(core_busy_i); nreq = m_req; nstat = 0; set = 0; clr = 0;
    i = int'(PADDR[6:2]); wd = int'(PWDATA);
    for (int c = 0; c < 4; c++) begin
      w = m_wake(c);
      old = m_mode[c];
      if (old == 2) begin
        nstat |= 1 << c;
        if (m_slept[c] < 15) m_slept[c]++;
        if (w == 1) m_mode[c] = 0;
      end else if (old == 0) begin
        if (((m_req >> c) & 1) == 1 && w == 0) begin
          m_mode[c] = 1;
          m_wait[c] = 0;
        end
      end else begin
        if (w == 1) m_mode[c] = 0;
        else if (((busy >> c) & 1) == 0) m_mode[c] = 2;
        else if (m_tmo != 0 && m_wait[c] == m_tmo - 1) begin
          m_mode[c] = 0;
          set |= 1 << c;
        end else m_wait[c]++;
      end
      if (old == 2 || w == 1 || ((set >> c) & 1) == 1) nreq &= ~(1 << c);
    end
    if (PSEL && PENABLE && PWRITE) begin
      if (i == 0) nreq = wd & 'hF;
      if (i == 2) m_mask = wd & 'hF;
      if (i == 3) m_tmo = wd & 'hFFFF;
      if (i == 4) clr = wd & 'hF;
      if (i >= 8 && i < 12) m_slept[i-8] = 0;
    end
    m_err  = (m_err & ~clr) | set;
    m_req  = nreq;
    m_stat = nstat;
  endfunction
  task automatic step();
    @(posedge HCLK);
    if (HRESET) m_reset();
    else model_step();
    #1;
  endtask
  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask
  task automatic wr(input int i, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 12'(i << 2); PWDATA = d;
    step();
    idle();
  endtask
  task automatic rd(input int i, output logic [31:0] d, output logic e, output logic [31:0] x);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'(i << 2);
    #2;
    d = PRDATA; e = PSLVERR; x = exp_read(i);
    step();
    idle();
  endtask
  task automatic test_reset();
    logic [31:0] d, x;
    logic e;
    int idxs [6] = '{0, 1, 2, 3, 4, 8};
    logic [31:0] ex [6] = '{32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0};
    HRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'(2 << 2);
    #2;
    total++; if (fetch_en_o !== 4'hF) begin bad++; $display("FAIL rst_fetch got=%h want=f", fetch_en_o); end
    total++; if (clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL rst_gate got=%h want=f", clk_gate_core_o); end
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL rst_prdata got=%h want=0", PRDATA); end
    total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL pready got=%b want=1", PREADY); end
    PADDR = 12'(6 << 2);
    #1;
    total++; if (PSLVERR !== 1'b0) begin bad++; $display("FAIL rst_slverr got=%b want=0", PSLVERR); end
    step();
    idle();
    HRESET = 1'b0;
    m_reset();
    for (int k = 0; k < 6; k++) begin
      rd(idxs[k], d, e, x);
      total++; if (d !== ex[k]) begin bad++; $display("FAIL rst_reg%0d got=%h want=%h", idxs[k], d, ex[k]); end
    end
  endtask
  task automatic test_sleep_wake();
    logic [31:0] d, x;
    logic e;
    core_busy_i = 4'h0; signal_i = 4'h0;
    wr(0, 32'h1);
    #2;
    total++; if (fetch_en_o !== 4'hE) begin bad++; $display("FAIL req_fetch got=%h want=e", fetch_en_o); end
    step();
    #2;
    total++; if (fetch_en_o !== 4'hE || clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL shut_out got=%h/%h want=e/f", fetch_en_o, clk_gate_core_o); end
    step();
    #2;
    total++; if (clk_gate_core_o !== 4'hE || fetch_en_o !== 4'hF) begin bad++; $display("FAIL sleep_out got=%h/%h want=f/e", fetch_en_o, clk_gate_core_o); end
    for (int k = 0; k < 6; k++) step();
    rd(0, d, e, x);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_clear got=%h want=0", d); end
    rd(1, d, e, x);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL status got=%h want=1", d); end
    signal_i = 4'h1;
    #2;
    total++; if (clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL wake_gate got=%h want=f", clk_gate_core_o); end
    step();
    signal_i = 4'h0;
    #2;
    total++; if (fetch_en_o !== 4'hF || clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL woke_out got=%h/%h want=f/f", fetch_en_o, clk_gate_core_o); end
    step();
    rd(8, d, e, x);
    total++; if (d !== x) begin bad++; $display("FAIL cnt0 got=%h want=%h", d, x); end
  endtask
  task automatic test_mask();
    wr(2, 32'hE);
    signal_i = 4'h1;
    wr(0, 32'h1);
    step();
    step();
    #2;
    total++; if (clk_gate_core_o !== 4'hE) begin bad++; $display("FAIL masked_sleep got=%h want=e", clk_gate_core_o); end
    step();
    wr(2, 32'hF);
    #2;
    total++; if (clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL unmask_wake got=%h want=f", clk_gate_core_o); end
    step();
    signal_i = 4'h0;
    #2;
    total++; if (fetch_en_o !== exp_fetch() || fetch_en_o !== 4'hF) begin bad++; $display("FAIL unmask_run got=%h want=f", fetch_en_o); end
    step();
  endtask
  task automatic test_timeout();
    logic [31:0] d, x;
    logic e;
    int n;
    wr(3, 32'd5);
    core_busy_i = 4'h2;
    wr(0, 32'h2);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (fetch_en_o[1] === 1'b0) n++;
      step();
    end
    total++; if (n !== 6) begin bad++; $display("FAIL tmo_cycles got=%0d want=6", n); end
    rd(4, d, e, x);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL err_set got=%h want=2", d); end
    rd(0, d, e, x);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL tmo_ctrl got=%h want=0", d); end
    wr(4, 32'h2);
    rd(4, d, e, x);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL err_w1c got=%h want=0", d); end
    wr(3, 32'd0);
    core_busy_i = 4'h0;
  endtask
  task automatic test_two_cores();
    core_busy_i = 4'h2;
    wr(0, 32'h3);
    for (int k = 0; k < 5; k++) step();
    #2;
    total++; if (clk_gate_core_o !== 4'hE || fetch_en_o !== 4'hD) begin bad++; $display("FAIL two_hold got=%h/%h want=d/e", fetch_en_o, clk_gate_core_o); end
    core_busy_i = 4'h0;
    step();
    #2;
    total++; if (clk_gate_core_o !== 4'hC) begin bad++; $display("FAIL two_sleep got=%h want=c", clk_gate_core_o); end
    signal_i = 4'h3;
    #1;
    total++; if (clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL two_wake got=%h want=f", clk_gate_core_o); end
    step();
    signal_i = 4'h0;
    #2;
    total++; if (fetch_en_o !== 4'hF || clk_gate_core_o !== 4'hF) begin bad++; $display("FAIL two_run got=%h/%h want=f/f", fetch_en_o, clk_gate_core_o); end
    step();
  endtask
  task automatic test_errors_sat();
    logic [31:0] d, x;
    logic e;
    int bad_idx [3] = '{5, 6, 12};
    for (int k = 0; k < 3; k++) begin
      rd(bad_idx[k], d, e, x);
      total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL unmapped%0d got=%h/%b want=0/1", bad_idx[k], d, e); end
    end
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 12'(7 << 2); PWDATA = 32'hFFFF_FFFF;
    #2;
    total++; if (PSLVERR !== 1'b1) begin bad++; $display("FAIL wr_slverr got=%b want=1", PSLVERR); end
    step();
    idle();
    #2;
    total++; if (PSLVERR !== 1'b0) begin bad++; $display("FAIL slverr_drop got=%b want=0", PSLVERR); end
    step();
    wr(10, 32'h0);
    wr(0, 32'h4);
    for (int k = 0; k < 22; k++) step();
    rd(10, d, e, x);
    total++; if (d !== 32'hF || d !== x) begin bad++; $display("FAIL cnt_sat got=%h want=f", d); end
    signal_i = 4'h4;
    step();
    signal_i = 4'h0;
    wr(10, 32'h1234);
    rd(10, d, e, x);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cnt_clr got=%h want=0", d); end
  endtask
  task automatic test_random();
    int i;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 4; c++) signal_i[c] = $urandom_range(0, 9) == 0;
      core_busy_i = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        i = $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(0, 15));
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'($urandom); PADDR = 12'(i << 2);
        PWDATA = i == 3 ? 32'($urandom_range(0, 8)) : i == 2 && $urandom_range(0, 3) != 0 ? 32'hF : $urandom;
      end else idle();
      #2;
      total++; if (fetch_en_o !== exp_fetch()) begin bad++; $display("FAIL rnd_fetch k=%0d got=%h want=%h", k, fetch_en_o, exp_fetch()); end
      total++; if (clk_gate_core_o !== exp_gate()) begin bad++; $display("FAIL rnd_gate k=%0d got=%h want=%h", k, clk_gate_core_o, exp_gate()); end
      total++; if (PRDATA !== exp_rdata()) begin bad++; $display("FAIL rnd_prdata k=%0d got=%h want=%h", k, PRDATA, exp_rdata()); end
      total++; if (PSLVERR !== exp_slverr()) begin bad++; $display("FAIL rnd_slverr k=%0d got=%b want=%b", k, PSLVERR, exp_slverr()); end
      step();
    end
    idle();
    signal_i = 4'h0;
  endtask
  task automatic test_reset_mid();
    logic [31:0] d, x;
    logic e;
    core_busy_i = 4'h0;
    wr(2, 32'hF);
    wr(3, 32'h0);
    wr(0, 32'h8);
    step();
    step();
    #2;
    total++; if (clk_gate_core_o[3] !== 1'b0 || clk_gate_core_o !== exp_gate()) begin bad++; $display("FAIL pre_rst got=%h want=%h", clk_gate_core_o, exp_gate()); end
    HRESET = 1'b1;
    m_reset();
    #1;
    total++; if (clk_gate_core_o !== 4'hF || fetch_en_o !== 4'hF) begin bad++; $display("FAIL mid_rst got=%h/%h want=f/f", fetch_en_o, clk_gate_core_o); end
    step();
    HRESET = 1'b0;
    rd(0, d, e, x);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL post_rst_ctrl got=%h want=0", d); end
  endtask
  initial begin
    total = 0; bad = 0;
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; signal_i = '0; core_busy_i = '0;
    idle();
    m_reset();
    @(posedge HCLK);
    #1;
    test_reset();
    test_sleep_wake();
    test_mask();
    test_timeout();
    test_two_cores();
    test_errors_sat();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sleep_unit_mc.md
Name: sleep_unit_mc

Overview:
Multi-core successor of the single-core APB sleep unit. It holds one RUN/SHUTDOWN/SLEEP controller per core and adds three features: per-core wake-source masking, a programmable shutdown timeout with error reporting, and saturating per-core sleep-cycle counters. It sits on the peripheral APB bus next to the event unit and drives each core's fetch enable and clock gate.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (minimum 7).
NB_CORES, 4, number of controlled cores; legal range 1..8.
CNT_WIDTH, 32, sleep-counter width; legal range 1..32; counter reads are zero-extended.

Ports:
HCLK  in  1  clock
HRESET  in  1  reset, asynchronous, active-high
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  APB write data
PWRITE  in  1  APB write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  constant 1
PSLVERR  out  1  error on unmapped access
signal_i  in  NB_CORES  per-core interrupt/event pending
core_busy_i  in  NB_CORES  per-core busy
fetch_en_o  out  NB_CORES  per-core fetch enable
clk_gate_core_o  out  NB_CORES  per-core clock enable; 0 gates the clock

Behaviour:
- Reset: all FSMs in RUN; CTRL=0, STATUS=0, ERR=0, TIMEOUT=0, counters=0, MASK=all ones. Outputs during reset: fetch_en_o all 1, clk_gate_core_o all 1, PRDATA 0, PSLVERR 0.
- Register word index is PADDR[6:2]:
  - 0 CTRL, RW: bit c is core c's sleep request.
  - 1 STATUS, RO: bit c=1 when core c is in SLEEP (registered, so it lags the state by 1 cycle).
  - 2 MASK, RW: bit c enables signal_i[c] as a wake source.
  - 3 TIMEOUT, RW, 16 bits [15:0]: 0 disables the timeout.
  - 4 ERR, write-1-to-clear.
  - 8+c CNT[c], RW: any write clears the counter to 0.
  - Mapped bits above NB_CORES read 0 and ignore writes.
- APB: access phase is PSEL&PENABLE; zero wait states.
  - Read: PRDATA is combinational from the registers during the access phase, otherwise 0.
  - Unmapped index (5-7, >=8+NB_CORES): read returns 0, write is ignored, PSLVERR=1 for that access phase only.
- Definition: wake[c] = signal_i[c] & MASK[c].
- Per-core FSM, transitions registered:
  - RUN: if CTRL[c] & !wake[c], go to SHUTDOWN. fetch_en_o[c] is 0 in that same cycle, so a sleep request followed immediately by WFI works. clk_gate=1.
  - SHUTDOWN: fetch_en=0, clk_gate=1. Timer tcnt[c] starts at 0 on entry and increments each cycle. Exits, in priority order:
    - wake[c]: go to RUN.
    - else !core_busy_i[c]: go to SLEEP.
    - else TIMEOUT!=0 and tcnt[c]==TIMEOUT-1: go to RUN and set ERR[c].
  - SLEEP: fetch_en=1, clk_gate_core_o[c]=wake[c] (combinational, so the clock restarts in the wake cycle); on wake[c] go to RUN. CNT[c] increments each cycle in SLEEP and saturates at all ones.
- CTRL[c] hardware clear, applied when the FSM is in SLEEP, or wake[c]=1, or a timeout abort occurs that cycle. An APB write to CTRL in the same cycle overrides the hardware clear.
- ERR set vs W1C in the same cycle: set wins.
- CNT increment vs APB write in the same cycle: the write wins (result 0).
- A masked signal_i never aborts shutdown and never wakes the core; unmasking while in SLEEP with signal_i high wakes the core the same cycle.
- Cores are fully independent; there is no cross-core interaction.
- HRESET asserted mid-operation: every FSM returns to RUN immediately (asynchronous) and outputs return to their reset values.

Test Plan:
- Reset, then read idx 0-4 and 8: CTRL 0, STATUS 0, MASK 0xF, TIMEOUT 0, ERR 0, CNT[0] 0; fetch_en_o=4'hF, clk_gate_core_o=4'hF.
- Write CTRL=0x1 with core_busy_i[0]=0, hold 10 cycles, then pulse signal_i[0]: fetch_en_o[0]=0 in the write+1 cycle; SLEEP and clk_gate_core_o[0]=0 the cycle after; CTRL reads 0; STATUS bit0=1; clk_gate=1 in the wake cycle; RUN next cycle; CNT[0] equals cycles spent in SLEEP.
- MASK=0xE, CTRL=0x1, signal_i[0]=1 throughout: core 0 still sleeps. Setting MASK=0xF wakes core 0 the same cycle.
- TIMEOUT=5, CTRL=0x2, core_busy_i[1]=1 held: core 1 spends 5 cycles in SHUTDOWN, then RUN; ERR=0x2 and CTRL bit1=0. Write ERR=0x2 and ERR reads 0.
- CTRL=0x3, core 0 idle, core 1 busy, no timeout: core 0 sleeps while core 1 stays in SHUTDOWN with fetch_en_o[1]=0; releasing busy sends core 1 to SLEEP.
- Read idx 6: PRDATA 0, PSLVERR 1. Set CNT width 4 and sleep 20 cycles: CNT reads 0xF. Assert HRESET while in SLEEP: clk_gate_core_o returns to all 1 immediately.
